// File: rtl/cpu_mcycle_bus_if.sv
// ---------------------------------------------------------------------------
// cpu_mcycle_bus_if
//   Bundles the signals between the control unit, the external memory bus
//   and the M-cycle sequencer.
//   master : the control unit / memory side. It drives stall, nxt_kind,
//            nxt_adr, nxt_wdata and din, and observes the sequencer outputs.
//   slave  : the sequencer (cpu_mcycle_bus). It drives adr, rd, wr, dout,
//            dout_en, rdata, rdata_valid, tstate and mcyc_start.
// ---------------------------------------------------------------------------
interface cpu_mcycle_bus_if #(
    parameter int ADR_W = 16,
    parameter int DAT_W = 8
);
    // request side, sampled by the sequencer
    logic             stall;
    logic [1:0]       nxt_kind;
    logic [ADR_W-1:0] nxt_adr;
    logic [DAT_W-1:0] nxt_wdata;
    logic [DAT_W-1:0] din;

    // registered outputs of the sequencer
    logic [ADR_W-1:0] adr;
    logic             rd;
    logic             wr;
    logic [DAT_W-1:0] dout;
    logic             dout_en;
    logic [DAT_W-1:0] rdata;
    logic             rdata_valid;
    logic [1:0]       tstate;
    logic             mcyc_start;

    modport master (
        output stall, nxt_kind, nxt_adr, nxt_wdata, din,
        input  adr, rd, wr, dout, dout_en, rdata, rdata_valid, tstate, mcyc_start
    );

    modport slave (
        input  stall, nxt_kind, nxt_adr, nxt_wdata, din,
        output adr, rd, wr, dout, dout_en, rdata, rdata_valid, tstate, mcyc_start
    );
endinterface

// File: rtl/cpu_mcycle_bus.sv
// ---------------------------------------------------------------------------
// cpu_mcycle_bus
//   M-cycle bus sequencer. Each M-cycle is four T-states (T1..T4). On the
//   edge leaving T4 (unless stalled) the next access (idle/read/write) is
//   latched, then address, strobes and write data are driven with fixed
//   T-state timing. Reads capture din at the end of T(RD_SAMPLE_T) and
//   return it as rdata with a one-clock rdata_valid pulse.
// Ports
//   clk    : system clock, one T-state per cycle
//   reset  : synchronous, active-high; wins over every other input
//   bus    : cpu_mcycle_bus_if.slave
//            in : stall, nxt_kind, nxt_adr, nxt_wdata, din
//            out: adr, rd, wr, dout, dout_en, rdata, rdata_valid,
//                 tstate, mcyc_start (all registered)
// ---------------------------------------------------------------------------
module cpu_mcycle_bus #(
    parameter int ADR_W       = 16,
    parameter int DAT_W       = 8,
    parameter int RD_SAMPLE_T = 3    // 2 or 3
) (
    input  logic             clk,
    input  logic             reset,
    cpu_mcycle_bus_if.slave  bus
);

    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2,
        T4 = 2'd3
    } tstate_e;

    typedef enum logic [1:0] {
        K_IDLE  = 2'd0,
        K_READ  = 2'd1,
        K_WRITE = 2'd2
    } kind_e;

    // T-state whose closing edge samples din; anything other than 2 maps to T3
    localparam tstate_e SAMPLE_T = (RD_SAMPLE_T == 2) ? T2 : T3;

    tstate_e          tstate_q,      tstate_d;
    kind_e            kind_q,        kind_d;
    logic [ADR_W-1:0] adr_q,         adr_d;
    logic [DAT_W-1:0] wdata_q,       wdata_d;
    logic [DAT_W-1:0] dout_q,        dout_d;
    logic             dout_en_q,     dout_en_d;
    logic             rd_q,          rd_d;
    logic             wr_q,          wr_d;
    logic [DAT_W-1:0] rdata_q,       rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             mcyc_start_q,  mcyc_start_d;
    logic             latch;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tstate_q      <= T4;
            kind_q        <= K_IDLE;
            adr_q         <= '0;
            wdata_q       <= '0;
            dout_q        <= '0;
            dout_en_q     <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            mcyc_start_q  <= 1'b0;
        end else begin
            tstate_q      <= tstate_d;
            kind_q        <= kind_d;
            adr_q         <= adr_d;
            wdata_q       <= wdata_d;
            dout_q        <= dout_d;
            dout_en_q     <= dout_en_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            mcyc_start_q  <= mcyc_start_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------
    always_comb begin
        tstate_d      = tstate_q;
        kind_d        = kind_q;
        adr_d         = adr_q;
        wdata_d       = wdata_q;
        dout_d        = dout_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        latch = (tstate_q == T4) && !bus.stall;

        // T counter; stall only matters in T4
        unique case (tstate_q)
            T1:      tstate_d = T2;
            T2:      tstate_d = T3;
            T3:      tstate_d = T4;
            default: tstate_d = bus.stall ? T4 : T1;
        endcase

        // Latch the next request; reserved kind 3 runs as idle and idle
        // M-cycles leave the address bus where it was.
        if (latch) begin
            unique case (bus.nxt_kind)
                2'd1:    kind_d = K_READ;
                2'd2:    kind_d = K_WRITE;
                default: kind_d = K_IDLE;
            endcase
            if (kind_d != K_IDLE) adr_d   = bus.nxt_adr;
            if (kind_d == K_WRITE) wdata_d = bus.nxt_wdata;
        end

        // Write data goes onto dout on entry to T2 and then just holds
        if (kind_q == K_WRITE && tstate_q == T1) dout_d = wdata_q;

        // Read capture at the end of the sample T-state
        if (kind_q == K_READ && tstate_q == SAMPLE_T) begin
            rdata_d       = bus.din;
            rdata_valid_d = 1'b1;
        end

        // Strobes are decoded from the state being entered so that they
        // come straight out of flops. wr is confined to T2..T3, which keeps
        // it clear of any rd in the neighbouring M-cycle.
        rd_d         = (kind_d == K_READ);
        wr_d         = (kind_d == K_WRITE) && (tstate_d == T2 || tstate_d == T3);
        dout_en_d    = (kind_d == K_WRITE) && (tstate_d != T1);
        mcyc_start_d = (tstate_d == T1);
    end

    assign bus.adr         = adr_q;
    assign bus.rd          = rd_q;
    assign bus.wr          = wr_q;
    assign bus.dout        = dout_q;
    assign bus.dout_en     = dout_en_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.tstate      = tstate_q;
    assign bus.mcyc_start  = mcyc_start_q;

endmodule
